// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage controller. It drives the instruction memory,
//   steers the external PC unit and owns the IF/ID pipeline register.
//
//   A four-state FSM (IDLE, FETCH, HOLD, DRAIN) handles:
//     - memory wait states: a bubble goes to ID and the address is held steady;
//     - ID back-pressure: the word fetched in a stall cycle is parked in a
//       one-entry hold buffer;
//     - redirects from ID: the younger fetch is squashed. An access still in
//       flight is finished against the address latched when the branch was
//       seen, and its data is discarded.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   PCOut                current fetch address from the PC unit
//   PCWrite, PCNext      PC update enable / value to the PC unit (combinational)
//   IMemReq, IMemAddr    instruction memory request / address (combinational)
//   IMemReady, IMemRdata memory handshake and returned word
//   Stall                ID cannot accept a new instruction
//   BranchTaken/Target   redirect request and target from ID
//   IF_ID_PC4/Instr/Valid registered IF/ID pipeline contents
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCOut,
    output logic        PCWrite,
    output logic [31:0] PCNext,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemRdata,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state_reg;
    logic [31:0] if_id_pc4_reg;
    logic [31:0] if_id_instr_reg;
    logic        if_id_valid_reg;
    logic [31:0] hold_pc4_reg;
    logic [31:0] hold_instr_reg;
    logic [31:0] drain_addr_reg;
    logic [31:0] pc_plus4;

    // Natural 32-bit wrap: 0xFFFFFFFC + 4 -> 0x00000000.
    assign pc_plus4 = PCOut + 32'd4;

    assign IF_ID_PC4   = if_id_pc4_reg;
    assign IF_ID_Instr = if_id_instr_reg;
    assign IF_ID_Valid = if_id_valid_reg;

    // PC unit and memory controls. PCWrite stays low during a FETCH wait
    // state, so PCOut (and therefore IMemAddr) cannot move until the memory
    // accepts the request.
    always_comb begin
        PCWrite  = 1'b0;
        PCNext   = pc_plus4;
        IMemReq  = 1'b0;
        IMemAddr = PCOut;
        if (!reset) begin
            case (state_reg)
                FETCH: begin
                    IMemReq = 1'b1;
                    PCWrite = IMemReady;
                end
                DRAIN: begin
                    // PCOut already points at the branch target here, so the
                    // outstanding access is finished on the latched address.
                    IMemReq  = 1'b1;
                    IMemAddr = drain_addr_reg;
                end
                default: ;
            endcase
            // A redirect overrides the sequential PC in every active state.
            if (state_reg != IDLE && BranchTaken) begin
                PCWrite = 1'b1;
                PCNext  = BranchTarget;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            if_id_pc4_reg   <= 32'd0;
            if_id_instr_reg <= NOP_INSTR;
            if_id_valid_reg <= 1'b0;
            hold_pc4_reg    <= 32'd0;
            hold_instr_reg  <= 32'd0;
            drain_addr_reg  <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: state_reg <= FETCH;

                FETCH: begin
                    if (BranchTaken) begin
                        // Flush beats Stall. The returned word (if any) is dropped.
                        if_id_instr_reg <= NOP_INSTR;
                        if_id_valid_reg <= 1'b0;
                        if (!IMemReady) begin
                            drain_addr_reg <= PCOut;
                            state_reg      <= DRAIN;
                        end
                    end else if (IMemReady) begin
                        if (!Stall) begin
                            if_id_pc4_reg   <= pc_plus4;
                            if_id_instr_reg <= IMemRdata;
                            if_id_valid_reg <= 1'b1;
                        end else begin
                            // PC has already advanced, so park the word.
                            hold_pc4_reg   <= pc_plus4;
                            hold_instr_reg <= IMemRdata;
                            state_reg      <= HOLD;
                        end
                    end else if (!Stall) begin
                        if_id_instr_reg <= NOP_INSTR;
                        if_id_valid_reg <= 1'b0;
                    end
                end

                HOLD: begin
                    // Leaving HOLD on a branch discards the hold buffer.
                    if (BranchTaken) begin
                        if_id_instr_reg <= NOP_INSTR;
                        if_id_valid_reg <= 1'b0;
                        state_reg       <= FETCH;
                    end else if (!Stall) begin
                        if_id_pc4_reg   <= hold_pc4_reg;
                        if_id_instr_reg <= hold_instr_reg;
                        if_id_valid_reg <= 1'b1;
                        state_reg       <= FETCH;
                    end
                end

                DRAIN: begin
                    if (BranchTaken || !Stall) begin
                        if_id_instr_reg <= NOP_INSTR;
                        if_id_valid_reg <= 1'b0;
                    end
                    if (IMemReady) state_reg <= FETCH;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_start;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ready;
    logic [31:0] rdata;
    logic        stall;
    logic        bt;
    logic [31:0] target;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .PCOut(pc), .PCWrite(pc_write), .PCNext(pc_next),
        .IMemReq(imem_req), .IMemAddr(imem_addr), .IMemReady(ready), .IMemRdata(rdata),
        .Stall(stall), .BranchTaken(bt), .BranchTarget(target),
        .IF_ID_PC4(pc4), .IF_ID_Instr(instr), .IF_ID_Valid(valid)
    );

    // Behavioural memory: each address holds a distinct word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign rdata = mem_word(imem_addr);

    // PC unit: presents PCNext one cycle after PCWrite.
    always_ff @(posedge clk) begin
        if (reset) pc <= pc_start;
        else if (pc_write) pc <= pc_next;
    end

    // Reset the DUT with the PC unit starting at 'start'. Returns at the
    // negedge of the IDLE cycle with reset released.
    task automatic do_reset(input logic [31:0] start);
        pc_start = start;
        reset = 1'b1; ready = 1'b0; stall = 1'b0; bt = 1'b0; target = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        pc_start = 32'h0; reset = 1'b1; ready = 1'b1; stall = 1'b0; bt = 1'b1; target = 32'h40;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%0h exp=0", imem_req); end
        tests++; if (pc_write !== 1'b0) begin fails++; $display("FAIL reset_pcwrite got=%0h exp=0", pc_write); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0h exp=0", valid); end
        tests++; if (instr !== NOP) begin fails++; $display("FAIL reset_instr got=%08h exp=%08h", instr, NOP); end
        tests++; if (pc4 !== 32'd0) begin fails++; $display("FAIL reset_pc4 got=%08h exp=0", pc4); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_sequential;
        do_reset(32'h0);
        ready = 1'b1; #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL seq_idle_req got=%0h exp=0", imem_req); end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++; if (imem_addr !== 32'(4*k)) begin fails++; $display("FAIL seq_addr got=%08h exp=%08h", imem_addr, 32'(4*k)); end
            tests++; if (pc_write !== 1'b1 || pc_next !== 32'(4*k+4)) begin fails++; $display("FAIL seq_pcnext got=%0h/%08h exp=1/%08h", pc_write, pc_next, 32'(4*k+4)); end
            @(negedge clk);
            tests++; if (pc4 !== 32'(4*k+4) || valid !== 1'b1 || instr !== mem_word(32'(4*k))) begin
                fails++; $display("FAIL seq_ifid got=%08h/%08h/%0h exp=%08h/%08h/1", pc4, instr, valid, 32'(4*k+4), mem_word(32'(4*k)));
            end
            $display("[TB] seq fetch pc4=%08h", pc4);
        end
    endtask

    task automatic test_ready_low;
        do_reset(32'h40);
        @(negedge clk);
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (pc_write !== 1'b0 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin
                fails++; $display("FAIL wait_hold got=%0h/%08h/%0h exp=0/00000040/1", pc_write, imem_addr, imem_req);
            end
            @(negedge clk);
            tests++; if (valid !== 1'b0 || instr !== NOP) begin fails++; $display("FAIL wait_bubble got=%0h/%08h exp=0/%08h", valid, instr, NOP); end
        end
        ready = 1'b1;
        @(negedge clk);
        tests++; if (pc4 !== 32'h44 || valid !== 1'b1 || instr !== mem_word(32'h40)) begin
            fails++; $display("FAIL wait_done got=%08h/%0h exp=00000044/1", pc4, valid);
        end
        $display("[TB] test_ready_low done");
    endtask

    task automatic test_hold;
        do_reset(32'h7C);
        @(negedge clk);
        ready = 1'b1; stall = 1'b0;
        @(negedge clk);                 // IF/ID now holds the 0x7C word
        stall = 1'b1; #1;               // ready cycle at 0x80 with stall
        tests++; if (imem_addr !== 32'h80 || pc_write !== 1'b1) begin fails++; $display("FAIL hold_cap got=%08h/%0h exp=00000080/1", imem_addr, pc_write); end
        @(negedge clk); #1;             // HOLD, still stalled
        tests++; if (imem_req !== 1'b0 || pc_write !== 1'b0) begin fails++; $display("FAIL hold_idle got=%0h/%0h exp=0/0", imem_req, pc_write); end
        tests++; if (pc4 !== 32'h80 || valid !== 1'b1 || instr !== mem_word(32'h7C)) begin fails++; $display("FAIL hold_keep got=%08h/%0h exp=00000080/1", pc4, valid); end
        stall = 1'b0;
        @(negedge clk); #1;
        tests++; if (pc4 !== 32'h84 || valid !== 1'b1 || instr !== mem_word(32'h80)) begin fails++; $display("FAIL hold_release got=%08h/%08h/%0h exp=00000084/%08h/1", pc4, instr, valid, mem_word(32'h80)); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h84) begin fails++; $display("FAIL hold_next got=%0h/%08h exp=1/00000084", imem_req, imem_addr); end
        $display("[TB] test_hold done");
    endtask

    task automatic test_branch_drain;
        do_reset(32'h100);
        @(negedge clk);
        ready = 1'b0; bt = 1'b1; target = 32'h200; #1;
        tests++; if (pc_write !== 1'b1 || pc_next !== 32'h200) begin fails++; $display("FAIL drain_redirect got=%0h/%08h exp=1/00000200", pc_write, pc_next); end
        @(negedge clk);
        bt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || pc_write !== 1'b0) begin
                fails++; $display("FAIL drain_addr got=%0h/%08h/%0h exp=1/00000100/0", imem_req, imem_addr, pc_write);
            end
            if (k == 1) ready = 1'b1;
            @(negedge clk);
        end
        #1;
        tests++; if (valid !== 1'b0 || instr !== NOP) begin fails++; $display("FAIL drain_drop got=%0h/%08h exp=0/%08h", valid, instr, NOP); end
        tests++; if (imem_addr !== 32'h200) begin fails++; $display("FAIL drain_next got=%08h exp=00000200", imem_addr); end
        @(negedge clk);
        tests++; if (pc4 !== 32'h204 || valid !== 1'b1 || instr !== mem_word(32'h200)) begin fails++; $display("FAIL drain_target got=%08h/%0h exp=00000204/1", pc4, valid); end
        $display("[TB] test_branch_drain done");
    endtask

    task automatic test_branch_stall;
        do_reset(32'h300);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        stall = 1'b1; bt = 1'b1; target = 32'h500; #1;
        tests++; if (pc_write !== 1'b1 || pc_next !== 32'h500) begin fails++; $display("FAIL bstall_pc got=%0h/%08h exp=1/00000500", pc_write, pc_next); end
        @(negedge clk);
        stall = 1'b0; bt = 1'b0; #1;
        tests++; if (valid !== 1'b0 || instr !== NOP) begin fails++; $display("FAIL bstall_flush got=%0h/%08h exp=0/%08h", valid, instr, NOP); end
        tests++; if (imem_addr !== 32'h500) begin fails++; $display("FAIL bstall_next got=%08h exp=00000500", imem_addr); end
        $display("[TB] test_branch_stall done");
    endtask

    task automatic test_wrap;
        do_reset(32'hFFFFFFFC);
        @(negedge clk);
        ready = 1'b1; #1;
        tests++; if (pc_next !== 32'h0) begin fails++; $display("FAIL wrap_pcnext got=%08h exp=00000000", pc_next); end
        @(negedge clk); #1;
        tests++; if (pc4 !== 32'h0 || valid !== 1'b1 || instr !== mem_word(32'hFFFFFFFC)) begin fails++; $display("FAIL wrap_ifid got=%08h/%0h exp=00000000/1", pc4, valid); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr got=%08h exp=00000000", imem_addr); end
        $display("[TB] test_wrap done");
    endtask

    // Program-order model: the stream of instructions ID accepts must be
    // sequential from the start address, jumping to the target after each
    // taken branch, with every word matching memory.
    task automatic test_random;
        logic [31:0] exp_pc;
        logic        prev_wait;
        logic [31:0] prev_addr;
        int          consumed;
        exp_pc = 32'h1000; prev_wait = 1'b0; prev_addr = 32'h0; consumed = 0;
        do_reset(32'h1000);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ready = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 3) == 0);
            bt = valid && !stall && ($urandom_range(0, 7) == 0);
            target = {16'h0, 4'h2, $urandom_range(0, 255) > 0 ? 10'($urandom_range(0, 1023)) : 10'd0, 2'b00};
            #1;
            if (prev_wait && imem_req) begin
                tests++; if (imem_addr !== prev_addr) begin fails++; $display("FAIL rnd_addr_stable got=%08h exp=%08h", imem_addr, prev_addr); end
            end
            if (bt) begin
                tests++; if (pc_write !== 1'b1 || pc_next !== target) begin fails++; $display("FAIL rnd_redirect got=%0h/%08h exp=1/%08h", pc_write, pc_next, target); end
            end
            if (valid && !stall) begin
                tests++; if (pc4 !== exp_pc + 32'd4 || instr !== mem_word(exp_pc)) begin
                    fails++; $display("FAIL rnd_order got=%08h/%08h exp=%08h/%08h", pc4, instr, exp_pc + 32'd4, mem_word(exp_pc));
                end
                $display("[TB] rnd consume pc=%08h branch=%0d", exp_pc, bt);
                exp_pc = bt ? target : exp_pc + 32'd4;
                consumed++;
            end else if (!valid) begin
                tests++; if (instr !== NOP) begin fails++; $display("FAIL rnd_bubble got=%08h exp=%08h", instr, NOP); end
            end
            prev_wait = imem_req && !ready;
            prev_addr = imem_addr;
        end
        tests++; if (consumed < 500) begin fails++; $display("FAIL rnd_progress got=%0d exp>=500", consumed); end
        bt = 1'b0; stall = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pc_start = 32'h0; ready = 1'b0; stall = 1'b0; bt = 1'b0; target = 32'h0;
        test_reset();
        test_sequential();
        test_ready_low();
        test_hold();
        test_branch_drain();
        test_branch_stall();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000000, is the instruction word inserted into IF/ID on bubble or flush.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 PCOut  input  32  current fetch address from the PC unit.
REQ-005 PCWrite  output  1  PC update enable to the PC unit.
REQ-006 PCNext  output  32  next PC value to the PC unit's PCIn.
REQ-007 IMemReq  output  1  instruction memory request.
REQ-008 IMemAddr  output  32  instruction memory address.
REQ-009 IMemReady  input  1  memory accepts request and returns data in the same cycle.
REQ-010 IMemRdata  input  32  instruction word, valid when IMemReq && IMemReady.
REQ-011 Stall  input  1  ID stage cannot accept a new instruction; hold IF/ID.
REQ-012 BranchTaken  input  1  redirect/flush request from ID.
REQ-013 BranchTarget  input  32  redirect address; valid with BranchTaken.
REQ-014 IF_ID_PC4  output  32  registered PC+4 of the instruction in IF/ID.
REQ-015 IF_ID_Instr  output  32  registered instruction word.
REQ-016 IF_ID_Valid  output  1  IF/ID holds a real instruction.

Function
REQ-017 FSM states: IDLE, FETCH, HOLD, DRAIN; encoding is free.
REQ-018 The PC unit presents PCNext on PCOut the cycle after PCWrite=1; the block relies on that 1-cycle latency.
REQ-019 IDLE: IMemReq=0, PCWrite=0; next state FETCH unconditionally.
REQ-020 FETCH: IMemReq=1, IMemAddr=PCOut; PCNext=PCOut+4 (mod 2^32, wrap 32'hFFFFFFFC -> 32'h00000000).
REQ-021 FETCH, Ready=1, Stall=0, BranchTaken=0: IF_ID <= {PCOut+4, IMemRdata, 1}; PCWrite=1; stay FETCH.
REQ-022 FETCH, Ready=1, Stall=1, BranchTaken=0: capture {PCOut+4, IMemRdata} in 1-entry hold buffer; PCWrite=1; IF_ID unchanged; go HOLD.
REQ-023 FETCH, Ready=0, BranchTaken=0: PCWrite=0; IMemAddr held stable; if Stall=0, IF_ID <= {IF_ID_PC4, NOP_INSTR, 0} (bubble); if Stall=1, IF_ID unchanged.
REQ-024 HOLD: IMemReq=0, PCWrite=0; if Stall=0, IF_ID <= {hold PC4, hold instr, 1}, go FETCH; else remain HOLD.
REQ-025 BranchTaken=1 in any non-IDLE state: PCWrite=1, PCNext=BranchTarget; IF_ID <= {IF_ID_PC4, NOP_INSTR, 0} regardless of Stall (flush beats Stall); hold buffer invalidated. No delay slot: all younger fetched words are squashed.
REQ-026 BranchTaken in FETCH with Ready=1: returned word discarded; stay FETCH.
REQ-027 BranchTaken in FETCH with Ready=0: latch PCOut into DrainAddr; go DRAIN.
REQ-028 DRAIN: IMemReq=1, IMemAddr=DrainAddr, PCWrite=0; on Ready=1 discard data, go FETCH; IF_ID receives bubble when Stall=0.
REQ-029 BranchTaken in HOLD: go FETCH. In DRAIN: update PCNext/PCWrite per REQ-025, remain DRAIN until Ready.
REQ-030 IMemAddr SHALL not change while IMemReq=1 and Ready=0.
REQ-031 PCWrite, PCNext, IMemReq, IMemAddr are combinational from state and inputs; IF_ID_* registered.

Reset
REQ-032 reset=1 at a posedge: state <= IDLE; IF_ID_PC4 <= 0; IF_ID_Instr <= NOP_INSTR; IF_ID_Valid <= 0; hold buffer and DrainAddr cleared.
REQ-033 While reset=1: IMemReq=0, PCWrite=0. Reset mid-DRAIN or mid-HOLD abandons the access; memory tolerates request drop under reset.

Verification
REQ-034 Reset release, PCOut=0, Ready=1 every cycle -> IDLE 1 cycle, then IMemAddr 0,4,8,...; IF_ID_PC4 4,8,12 with Valid=1.
REQ-035 Ready low 3 cycles at PCOut=0x40 -> PCWrite=0, IMemAddr=0x40 stable, 3 bubbles (Valid=0, Instr=NOP_INSTR), then IF_ID_PC4=0x44.
REQ-036 Stall=1 on Ready cycle at 0x80 for 2 cycles -> HOLD, IMemReq=0, IF_ID unchanged; Stall drop -> IF_ID_PC4=0x84, Valid=1, state FETCH at 0x84.
REQ-037 BranchTaken=1, Target=0x200 while FETCH waiting at 0x100 -> DRAIN at 0x100 until Ready, data dropped, next fetch 0x200; no word from 0x100 reaches IF_ID.
REQ-038 BranchTaken and Stall both 1 -> IF_ID_Valid=0 next cycle, PCNext=Target.
REQ-039 PCOut=0xFFFFFFFC, Ready=1 -> PCNext=0x00000000, IF_ID_PC4=0x00000000.
